// File: rtl/seg_display_pkg.sv
// Shared constants and types for the seven-segment display arbiter.
//   SEG_BLANK / AN_OFF : all-segments-off and all-anodes-off codes (active-low)
//   arb_state_e        : arbiter ownership state; OWN0/OWN1 map onto the grants
//   digit_byte()       : picks digit byte idx out of a packed 4-digit word
package seg_display_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'hF;
  localparam int         DIGIT_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // digit 0 lives in [7:0], digit 3 in [31:24]
  function automatic logic [7:0] digit_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[idx*DIGIT_W +: DIGIT_W];
  endfunction

endpackage

// File: rtl/seg_scan_mux.sv
// Free-running digit scanner. Each slot of SCAN_DIV cycles starts with
// BLANK_CYCLES of all-anodes-off, then lights digit idx with a byte that was
// snapshotted just before the lit window, so a digit never changes mid-slot.
//   clk, rst_n : clock, asynchronous active-low reset
//   word_i     : selected owner's four digit bytes
//   blank_i    : no owner; snapshot a blank digit instead of word_i
//   an_o       : anode enables, active-low (registered)
//   seg_o      : segment bus, active-low, bit 7 = dp (registered)
module seg_scan_mux
  import seg_display_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] word_i,
  input  logic        blank_i,
  output logic [3:0]  an_o,
  output logic [7:0]  seg_o
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] SNAP_AT   = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] LIT_AT    = CW'(BLANK_CYCLES);

  logic [CW-1:0] slot_q, slot_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    snap_q, snap_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;

  always_comb begin
    slot_d = slot_q + 1'b1;
    idx_d  = idx_q;
    if (slot_q == SLOT_LAST) begin
      slot_d = '0;
      idx_d  = idx_q + 2'd1;
    end

    snap_d = snap_q;
    if (slot_q == SNAP_AT)
      snap_d = blank_i ? SEG_BLANK : digit_byte(word_i, idx_q);

    // an/seg are registered from the next slot position so that the pins
    // always agree with the slot counter value held in the same cycle
    if (slot_d < LIT_AT) begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
    end else begin
      an_d  = ~(4'b0001 << idx_d);
      seg_d = snap_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      idx_q  <= '0;
      snap_q <= SEG_BLANK;
      an_q   <= AN_OFF;
      seg_q  <= SEG_BLANK;
    end else begin
      slot_q <= slot_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares one 4-digit seven-segment display between a low-priority heartbeat
// source (0) and a high-priority status source (1). Source 1 may preempt
// source 0 only after source 0 has owned the display for HOLD_MIN cycles;
// source 0 never preempts source 1. Releases pass through IDLE for one cycle.
//   clk, reset        : clock, asynchronous active-low reset
//   req_0/1, digs_0/1 : per-source request and packed digit bytes
//   grant_0/1         : registered ownership flags (at most one high)
//   an, seg           : display pins, active-low
module seg_display_arbiter
  import seg_display_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int HOLD_MIN     = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_0,
  input  logic [31:0] digs_0,
  input  logic        req_1,
  input  logic [31:0] digs_1,
  output logic        grant_0,
  output logic        grant_1,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int HW = $clog2(HOLD_MIN + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MIN - 1);

  arb_state_e    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_1)      state_d = OWN1;
        else if (req_0) state_d = OWN0;
      end
      OWN0: begin
        if (!req_0)                            state_d = IDLE;
        else if (req_1 && hold_q == HOLD_LAST) state_d = OWN1;
      end
      OWN1: begin
        if (!req_1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // counts only while source 0 keeps ownership; any transition clears it
    hold_d = '0;
    if (state_q == OWN0 && state_d == OWN0)
      hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign grant_0 = (state_q == OWN0);
  assign grant_1 = (state_q == OWN1);

  seg_scan_mux #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_scan (
    .clk     (clk),
    .rst_n   (reset),
    .word_i  ((state_q == OWN1) ? digs_1 : digs_0),
    .blank_i (state_q == IDLE),
    .an_o    (an),
    .seg_o   (seg)
  );

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench: the driver applies inputs on the falling edge, advances a
// behavioural model of the display and queues the expected pin values for the
// next rising edge; the monitor pops and compares just after each rising edge.
module tb_seg_display_arbiter;

  localparam int SCAN_DIV = 8;
  localparam int BLANK    = 2;
  localparam int HOLD_MIN = 16;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic        req_0  = 1'b0;
  logic        req_1  = 1'b0;
  logic [31:0] digs_0 = 32'hFFFF_FFFF;
  logic [31:0] digs_1 = 32'hFFFF_FFFF;
  logic        grant_0, grant_1;
  logic [3:0]  an;
  logic [7:0]  seg;

  seg_display_arbiter #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK),
    .HOLD_MIN     (HOLD_MIN)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req_0   (req_0),
    .digs_0  (digs_0),
    .req_1   (req_1),
    .digs_1  (digs_1),
    .grant_0 (grant_0),
    .grant_1 (grant_1),
    .an      (an),
    .seg     (seg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        g0;
    logic        g1;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // model: elapsed cycles since reset release, owner (0 none, 1 src0, 2 src1),
  // cycles the current owner has held, digit latched for the lit window
  int         m_k, m_own, m_held;
  logic [7:0] m_snap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_k = 0; m_own = 0; m_held = 0; m_snap = 8'hFF;
  endtask

  task automatic model_step();
    exp_t e;
    int   slot, idx;
    logic [31:0] w;
    slot = m_k % SCAN_DIV;
    idx  = (m_k / SCAN_DIV) % 4;
    if (slot == BLANK - 1) begin
      w = (m_own == 1) ? digs_0 : digs_1;
      m_snap = (m_own == 0) ? 8'hFF : 8'((w >> (8 * idx)) & 32'hFF);
    end
    case (m_own)
      0: begin
        m_own  = req_1 ? 2 : (req_0 ? 1 : 0);
        m_held = 0;
      end
      1: begin
        if (!req_0) begin
          m_own = 0; m_held = 0;
        end else if (req_1 && m_held >= HOLD_MIN - 1) begin
          m_own = 2; m_held = 0;
        end else begin
          m_held++;
        end
      end
      default: if (!req_1) m_own = 0;
    endcase
    m_k++;
    slot  = m_k % SCAN_DIV;
    idx   = (m_k / SCAN_DIV) % 4;
    e.g0  = (m_own == 1);
    e.g1  = (m_own == 2);
    e.an  = (slot < BLANK) ? 4'hF : 4'(~(32'd1 << idx));
    e.seg = (slot < BLANK) ? 8'hFF : m_snap;
    e.cyc = 32'(m_k);
    sb.push_back(e);
  endtask

  task automatic drive(input logic r0, input logic r1, input logic [31:0] d0, input logic [31:0] d1);
    @(negedge clk);
    req_0 = r0; req_1 = r1; digs_0 = d0; digs_1 = d1;
    if (reset) model_step();
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    model_step();
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset && sb.size() > 0) begin
      e = sb.pop_front();
      chk("grant_0", 32'(grant_0), 32'(e.g0));
      chk("grant_1", 32'(grant_1), 32'(e.g1));
      chk("an", 32'(an), 32'(e.an));
      chk("seg", 32'(seg), 32'(e.seg));
      chk("grant_onehot", 32'(grant_0 & grant_1), 32'd0);
    end
  end

  initial begin
    logic [31:0] d0, d1;
    logic        r0, r1;
    bit          found;

    #2 reset = 1'b0;
    #1;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_g0", 32'(grant_0), 32'd0);
    chk("rst_g1", 32'(grant_1), 32'd0);

    release_reset();
    repeat (5) drive(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // asynchronous reset in the middle of a lit digit-0 window
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      drive(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      if (an == 4'hE) found = 1'b1;
    end
    if (!found) begin
      n_chk++; n_fail++;
      $display("FAIL wait_an_E: got %0h expected e within 64 cycles", an);
    end
    #2 reset = 1'b0;
    sb.delete();
    #1;
    chk("async_an", 32'(an), 32'hF);
    chk("async_seg", 32'(seg), 32'hFF);
    chk("async_g0", 32'(grant_0), 32'd0);
    chk("async_g1", 32'(grant_1), 32'd0);
    repeat (3) @(negedge clk);
    chk("held_an", 32'(an), 32'hF);
    release_reset();
    repeat (4) drive(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // source 0 alone
    repeat (40) drive(1'b1, 1'b0, 32'hF9CF_FFFF, 32'hFFFF_FFFF);
    repeat (2)  drive(1'b0, 1'b0, 32'hF9CF_FFFF, 32'hFFFF_FFFF);
    // simultaneous requests: source 1 wins
    repeat (40) drive(1'b1, 1'b1, 32'hF9CF_FFFF, 32'h3F5B_4F66);
    // source 1 drops with source 0 waiting: one IDLE cycle, then source 0
    repeat (6)  drive(1'b1, 1'b0, 32'hF9CF_FFFF, 32'h3F5B_4F66);
    // source 1 returns early: held off until the hold time, then preempts
    repeat (30) drive(1'b1, 1'b1, 32'hF9CF_FFFF, 32'h3F5B_4F66);
    repeat (20) drive(1'b1, 1'b0, 32'hF9CF_FFFF, 32'h3F5B_4F66);
    // byte 2 changes mid-slot
    for (int i = 0; i < 60; i++)
      drive(1'b1, 1'b0, (i < 27) ? 32'hF9CF_FFFF : 32'hF9F9_FFFF, 32'h3F5B_4F66);

    // random traffic with long-lived requests
    r0 = 1'b0; r1 = 1'b0; d0 = $urandom; d1 = $urandom;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(23) == 0) r0 = ~r0;
      if ($urandom_range(29) == 0) r1 = ~r1;
      if ($urandom_range(9) == 0)  d0 = $urandom;
      if ($urandom_range(9) == 0)  d1 = $urandom;
      drive(r0, r1, d0, d1);
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
